// File: rtl/cellrv32_io_responder_pkg.sv
// Shared definitions for the IO-space test responder: window, register map, field positions
// and FSM state type.
package cellrv32_io_responder_pkg;

   localparam logic [31:0] iores_base_c = 32'hFFFF_FE80;
   localparam int unsigned iores_size_c = 32;

   // Upper bound the bus keeper allows before declaring a timeout.
   localparam int unsigned max_proc_int_response_time_c = 32;

   localparam logic [2:0] iores_ctrl_c     = 3'd0;
   localparam logic [2:0] iores_status_c   = 3'd1;
   localparam logic [2:0] iores_scratch0_c = 3'd2;

   localparam int unsigned ctrl_wait_lsb_c = 0;
   localparam int unsigned ctrl_wait_msb_c = 3;
   localparam int unsigned ctrl_mute_c     = 29;
   localparam int unsigned ctrl_clr_c      = 30;
   localparam int unsigned ctrl_ferr_c     = 31;

   localparam int unsigned stat_acc_lsb_c = 0;
   localparam int unsigned stat_acc_msb_c = 15;
   localparam int unsigned stat_err_lsb_c = 16;
   localparam int unsigned stat_err_msb_c = 30;
   localparam int unsigned stat_ovr_c     = 31;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp,
      StMute
   } iores_state_t;

   function automatic logic [31:0] iores_apply_ben(input logic [31:0] cur,
                                                   input logic [31:0] wdata,
                                                   input logic [3:0]  ben);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = ben[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/cellrv32_io_responder_cnt.sv
// Access/error statistics: wrapping access counter, saturating error counter, sticky overrun.
module cellrv32_io_responder_cnt
   import cellrv32_io_responder_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        acc_i,
   input  logic        err_i,
   input  logic        ovr_i,
   output logic [15:0] acc_cnt_o,
   output logic [14:0] err_cnt_o,
   output logic        overrun_o
);

   logic [15:0] acc_cnt_q;
   logic [14:0] err_cnt_q;
   logic        overrun_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_cnt_q <= '0;
         err_cnt_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (clr_i) begin
            acc_cnt_q <= '0;
            err_cnt_q <= '0;
         end else begin
            if (acc_i) begin
               acc_cnt_q <= acc_cnt_q + 16'd1;
            end
            if (err_i && (err_cnt_q != 15'h7FFF)) begin
               err_cnt_q <= err_cnt_q + 15'd1;
            end
         end
         // A dropped request in the same cycle as a clear still leaves evidence.
         if (ovr_i) begin
            overrun_q <= 1'b1;
         end else if (clr_i) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign acc_cnt_o = acc_cnt_q;
   assign err_cnt_o = err_cnt_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/cellrv32_io_responder.sv
// IO-bus test responder: scratch/status registers with programmable wait states, forced error
// responses and an optional mute mode that lets the bus keeper time out.
module cellrv32_io_responder
   import cellrv32_io_responder_pkg::*;
#(
   parameter int unsigned BASE_WAIT       = 1,
   parameter bit          TIMEOUT_TEST_EN = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic        rden_i,
   input  logic        wren_i,
   input  logic [3:0]  ben_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int unsigned WinBits   = $clog2(iores_size_c);
   localparam logic [4:0]  BaseWaitC = 5'(BASE_WAIT);

   if ((BASE_WAIT > 7) || (BASE_WAIT + 15 >= max_proc_int_response_time_c)) begin : g_wait_chk
      $error("cellrv32_io_responder: BASE_WAIT too large for the bus keeper timeout");
   end

   iores_state_t state_q;
   logic [4:0]   cnt_q;
   logic [4:0]   addr_q;
   logic [31:0]  data_q;
   logic [3:0]   ben_q;
   logic         wr_q;
   logic         ack_q, err_q;
   logic [31:0]  rdata_q;

   logic [3:0]   ctrl_wait_q;
   logic         ctrl_mute_q;
   logic         ctrl_ferr_q;
   logic [31:0]  scratch_q [0:5];

   logic [15:0]  acc_cnt;
   logic [14:0]  err_cnt;
   logic         overrun;

   logic         sel, req, idle, mute_eff;
   logic [4:0]   wait_sum;
   logic [4:0]   cur_addr;
   logic [2:0]   cur_idx;
   logic [31:0]  cur_data;
   logic [3:0]   cur_ben;
   logic         cur_wr;
   logic         acc_err, go_resp, go_mute, reg_we, clr;
   logic [31:0]  ctrl_rd, ctrl_wdata, status_rd, rdata;

   assign sel      = (addr_i[31:WinBits] == iores_base_c[31:WinBits]);
   assign req      = sel && (rden_i || wren_i);
   assign idle     = (state_q == StIdle);
   assign mute_eff = TIMEOUT_TEST_EN && ctrl_mute_q;
   assign wait_sum = BaseWaitC + {1'b0, ctrl_wait_q};

   // Zero-wait accesses complete straight out of IDLE, so evaluate on the live request there.
   assign cur_addr = idle ? addr_i[4:0] : addr_q;
   assign cur_data = idle ? data_i : data_q;
   assign cur_ben  = idle ? ben_i : ben_q;
   assign cur_wr   = idle ? wren_i : wr_q;
   assign cur_idx  = cur_addr[4:2];

   assign go_resp = (idle && req && (wait_sum == 5'd0)) ||
                    ((state_q == StWait) && (cnt_q == 5'd1) && !mute_eff);
   assign go_mute = (state_q == StWait) && (cnt_q == 5'd1) && mute_eff;

   assign acc_err = ctrl_ferr_q || (cur_addr[1:0] != 2'b00) ||
                    (cur_wr && (cur_idx == iores_status_c));
   assign reg_we  = go_resp && cur_wr && !acc_err;

   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[ctrl_wait_msb_c:ctrl_wait_lsb_c] = ctrl_wait_q;
      ctrl_rd[ctrl_mute_c] = ctrl_mute_q;
      ctrl_rd[ctrl_ferr_c] = ctrl_ferr_q;
   end

   always_comb begin
      status_rd = '0;
      status_rd[stat_acc_msb_c:stat_acc_lsb_c] = acc_cnt;
      status_rd[stat_err_msb_c:stat_err_lsb_c] = err_cnt;
      status_rd[stat_ovr_c] = overrun;
   end

   assign ctrl_wdata = iores_apply_ben(ctrl_rd, cur_data, cur_ben);
   assign clr        = reg_we && (cur_idx == iores_ctrl_c) && ctrl_wdata[ctrl_clr_c];

   always_comb begin
      rdata = '0;
      unique case (cur_idx)
         iores_ctrl_c:   rdata = ctrl_rd;
         iores_status_c: rdata = status_rd;
         default:        rdata = scratch_q[cur_idx - iores_scratch0_c];
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ben_q   <= '0;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         if (go_resp) begin
            ack_q   <= !acc_err;
            err_q   <= acc_err;
            rdata_q <= (!acc_err && !cur_wr) ? rdata : 32'h0;
         end
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  addr_q  <= addr_i[4:0];
                  data_q  <= data_i;
                  ben_q   <= ben_i;
                  wr_q    <= wren_i;
                  cnt_q   <= wait_sum;
                  state_q <= (wait_sum == 5'd0) ? StResp : StWait;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_q <= mute_eff ? StMute : StResp;
               end
            end
            StResp: state_q <= StIdle;
            StMute: begin
               if (req) begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_wait_q <= '0;
         ctrl_mute_q <= 1'b0;
         ctrl_ferr_q <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            scratch_q[i] <= '0;
         end
      end else begin
         // Mute is one-shot: once the keeper has been starved the next access behaves normally.
         if (go_mute) begin
            ctrl_mute_q <= 1'b0;
         end
         if (go_resp) begin
            ctrl_ferr_q <= 1'b0;
            if (reg_we) begin
               if (cur_idx == iores_ctrl_c) begin
                  ctrl_wait_q <= ctrl_wdata[ctrl_wait_msb_c:ctrl_wait_lsb_c];
                  ctrl_mute_q <= TIMEOUT_TEST_EN && ctrl_wdata[ctrl_mute_c];
                  ctrl_ferr_q <= ctrl_wdata[ctrl_ferr_c];
               end else if (cur_idx != iores_status_c) begin
                  scratch_q[cur_idx - iores_scratch0_c] <=
                     iores_apply_ben(scratch_q[cur_idx - iores_scratch0_c], cur_data, cur_ben);
               end
            end
         end
      end
   end

   cellrv32_io_responder_cnt u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr),
      .acc_i     (go_resp && !clr),
      .err_i     (go_resp && acc_err),
      .ovr_i     (req && ((state_q == StWait) || (state_q == StResp))),
      .acc_cnt_o (acc_cnt),
      .err_cnt_o (err_cnt),
      .overrun_o (overrun)
   );

   assign data_o = rdata_q;
   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign busy_o = !idle;

endmodule

// File: tb/tb_cellrv32_io_responder.sv
// Scoreboard bench for cellrv32_io_responder: expected responses queued at request time and
// matched against responses captured on the falling clock edge.
module tb_cellrv32_io_responder;
   import cellrv32_io_responder_pkg::*;

   localparam int unsigned BaseWait = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, data_o;
   logic        rden, wren, ack_o, err_o, busy_o;
   logic [3:0]  ben;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t obs_q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   req_cyc = 0;
   int   ext_m = 0;

   cellrv32_io_responder #(
      .BASE_WAIT       (BaseWait),
      .TIMEOUT_TEST_EN (1'b1)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .addr_i (addr),
      .rden_i (rden),
      .wren_i (wren),
      .ben_i  (ben),
      .data_i (wdata),
      .data_o (data_o),
      .ack_o  (ack_o),
      .err_o  (err_o),
      .busy_o (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ack_o || err_o) obs_q.push_back('{ack_o, err_o, data_o, cyc});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   task automatic pulse(input logic wr, input logic rd, input logic [4:0] off,
                        input logic [31:0] d, input logic [3:0] be);
      @(posedge clk); #1;
      addr = iores_base_c + {27'b0, off};
      wren = wr; rden = rd; wdata = d; ben = be;
      req_cyc = cyc;
      @(posedge clk); #1;
      wren = 1'b0; rden = 1'b0;
   endtask

   task automatic issue(input logic wr, input logic [4:0] off, input logic [31:0] d,
                        input logic [3:0] be, input logic e_err, input logic [31:0] e_data);
      pulse(wr, !wr, off, d, be);
      exp_q.push_back('{!e_err, e_err, e_data, req_cyc + 1 + BaseWait + ext_m});
      for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; rden = 1'b0; wren = 1'b0; ben = '0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({ack_o, err_o, busy_o, data_o} !== 35'b0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%0b err=%0b busy=%0b data=%h, want all 0",
                  ack_o, err_o, busy_o, data_o);
      end
   endtask

   task automatic test_default_wait;
      rsp_t e, o;
      issue(1'b1, 5'd8, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd8, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001);
      issue(1'b0, 5'd4, 32'h0, 4'hF, 1'b0, 32'h0000_0002);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL default_wait: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL default_wait: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
   endtask

   task automatic test_byte_enable;
      rsp_t e, o;
      issue(1'b1, 5'd12, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
      issue(1'b1, 5'd12, 32'hFFFF_FFFF, 4'b0101, 1'b0, 32'h0);
      issue(1'b0, 5'd12, 32'h0, 4'h0, 1'b0, 32'h11FF_33FF);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL byte_enable: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL byte_enable: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
   endtask

   task automatic test_errors;
      rsp_t e, o;
      issue(1'b1, 5'd0, 32'h4000_0000, 4'hF, 1'b0, 32'h0);   // clear counters, not counted
      issue(1'b1, 5'd4, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
      issue(1'b0, 5'd10, 32'h0, 4'hF, 1'b1, 32'h0);
      issue(1'b1, 5'd0, 32'h8000_0000, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd8, 32'h0, 4'hF, 1'b1, 32'h0);
      issue(1'b0, 5'd4, 32'h0, 4'hF, 1'b0, 32'h0003_0004);
      issue(1'b0, 5'd0, 32'h0, 4'hF, 1'b0, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL errors: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL errors: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
   endtask

   task automatic test_wait_sweep;
      rsp_t e, o;
      int   c0;
      issue(1'b1, 5'd0, 32'h0000_000F, 4'hF, 1'b0, 32'h0);
      ext_m = 15;
      pulse(1'b0, 1'b1, 5'd8, 32'h0, 4'hF);
      c0 = req_cyc;
      exp_q.push_back('{1'b1, 1'b0, 32'hA5A5_0001, c0 + 17});
      repeat (3) @(posedge clk);
      #1;
      pulse(1'b0, 1'b1, 5'd12, 32'h0, 4'hF);               // lands at c0+5: overrun, dropped
      for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
      repeat (4) @(posedge clk);
      issue(1'b1, 5'd0, 32'h0, 4'hF, 1'b0, 32'h0);
      ext_m = 0;
      issue(1'b0, 5'd4, 32'h0, 4'hF, 1'b0, 32'h8003_0009);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL wait_sweep: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL wait_sweep: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL wait_sweep_stray: %0d extra responses, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_timeout;
      rsp_t e, o;
      issue(1'b1, 5'd0, 32'h2000_0000, 4'hF, 1'b0, 32'h0);
      pulse(1'b0, 1'b1, 5'd8, 32'h0, 4'hF);
      repeat (64) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size() || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL mute_hold: responses=%0d busy=%0b, want responses=%0d busy=1",
                  obs_q.size(), busy_o, exp_q.size());
      end
      pulse(1'b0, 1'b1, 5'd8, 32'h0, 4'hF);                // dropped, frees the FSM
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mute_release: busy=%0b, want 0", busy_o);
      end
      repeat (5) @(posedge clk);
      issue(1'b0, 5'd8, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001);
      issue(1'b0, 5'd0, 32'h0, 4'hF, 1'b0, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL timeout: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL timeout: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_stray: %0d extra responses, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid;
      rsp_t e, o;
      issue(1'b1, 5'd0, 32'h0000_0005, 4'hF, 1'b0, 32'h0);
      ext_m = 5;
      pulse(1'b0, 1'b1, 5'd12, 32'h0, 4'hF);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ext_m = 0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size() || {ack_o, err_o, busy_o, data_o} !== 35'b0) begin
         errors++;
         $display("FAIL reset_mid: responses=%0d ack=%0b err=%0b busy=%0b data=%h, want responses=%0d and all 0",
                  obs_q.size(), ack_o, err_o, busy_o, data_o, exp_q.size());
      end
      issue(1'b0, 5'd4, 32'h0, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd0, 32'h0, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd8, 32'h0, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd12, 32'h0, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 5'd28, 32'h0, 4'hF, 1'b0, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL reset_mid: no response, want ack=%0b err=%0b data=%h cycle %0d",
                     e.ack, e.err, e.data, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.ack !== e.ack || o.err !== e.err || o.data !== e.data || o.cyc != e.cyc) begin
               errors++;
               $display("FAIL reset_mid: got ack=%0b err=%0b data=%h cycle %0d, want ack=%0b err=%0b data=%h cycle %0d",
                        o.ack, o.err, o.data, o.cyc, e.ack, e.err, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_stray: %0d extra responses, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_default_wait();
      test_byte_enable();
      test_errors();
      test_wait_sweep();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
